// File: rtl/wb_fir_ctrl_pkg.sv
// wb_fir_ctrl_pkg: address map, FSM encodings and ap_ctrl layout for the FIR Wishbone front-end
package wb_fir_ctrl_pkg;
  localparam logic [7:0] BASE_HI_DEF = 8'h30;
  localparam logic [7:0] OFF_CTRL = 8'h00;
  localparam logic [7:0] OFF_LEN = 8'h10;
  localparam logic [7:0] OFF_TAP = 8'h40;
  localparam logic [7:0] OFF_IN = 8'h80;
  localparam logic [7:0] OFF_OUT = 8'h84;
  localparam logic [7:0] OFF_IN_RD = 8'h88;
  localparam int AP_START = 0;
  localparam int AP_DONE = 1;
  localparam int AP_IDLE = 2;
  typedef enum logic [1:0] {R_IDLE, R_RUN, R_DONE} run_state_e;
  typedef enum logic [1:0] {B_IDLE, B_ACK, B_TRD, B_FWD} bus_state_e;
  function automatic logic [31:0] ap_status(run_state_e s);
    ap_status = '0;
    ap_status[AP_START] = s == R_RUN;
    ap_status[AP_DONE] = s == R_DONE;
    ap_status[AP_IDLE] = s != R_RUN;
  endfunction
endpackage

// File: rtl/wb_fir_ctrl_if.sv
// wb_fir_ctrl_if: Caravel Wishbone slave bus bundle
interface wb_fir_ctrl_if;
  logic        wbs_stb_i;
  logic        wbs_cyc_i;
  logic        wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i;
  logic [31:0] wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  modport master (output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
                  input wbs_ack_o, wbs_dat_o);
  modport slave (input wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
                 output wbs_ack_o, wbs_dat_o);
endinterface

// File: rtl/wb_fir_ctrl_seq.sv
// wb_fir_ctrl_seq: FIR run sequencer counting stream handshakes from start to done
module wb_fir_ctrl_seq
  import wb_fir_ctrl_pkg::*;
(
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic        clr_i,
  input  logic        ss_hs_i,
  input  logic        sm_hs_i,
  input  logic [31:0] data_len_i,
  output run_state_e  state_o,
  output logic        ap_start_o
);
  run_state_e  state_q;
  logic [31:0] in_cnt_q;
  logic [31:0] out_cnt_q;
  logic        ap_start_q;
  // run FSM with saturating handshake counters; the last output handshake ends the run
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= R_IDLE;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      ap_start_q <= 1'b0;
    end else begin
      ap_start_q <= 1'b0;
      case (state_q)
        R_IDLE: if (start_i && data_len_i != '0) begin
          state_q    <= R_RUN;
          ap_start_q <= 1'b1;
          in_cnt_q   <= '0;
          out_cnt_q  <= '0;
        end
        R_RUN: begin
          if (ss_hs_i && in_cnt_q < data_len_i) in_cnt_q <= in_cnt_q + 32'd1;
          if (sm_hs_i && out_cnt_q < data_len_i) out_cnt_q <= out_cnt_q + 32'd1;
          if (sm_hs_i && out_cnt_q == data_len_i - 32'd1) state_q <= R_DONE;
        end
        R_DONE: if (clr_i) state_q <= R_IDLE;
        default: state_q <= R_IDLE;
      endcase
    end
  end
  assign state_o = state_q;
  assign ap_start_o = ap_start_q;
endmodule

// File: rtl/wb_fir_ctrl.sv
// wb_fir_ctrl: Wishbone decode, config registers, tap access and stream forwarding for the FIR
module wb_fir_ctrl
  import wb_fir_ctrl_pkg::*;
#(
  parameter int         pADDR_WIDTH = 12,
  parameter int         pDATA_WIDTH = 32,
  parameter int         Tape_Num = 11,
  parameter logic [7:0] BASE_HI = BASE_HI_DEF
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  wb_fir_ctrl_if.slave           wb,
  output logic                   fwd_stb_o,
  output logic                   fwd_out_o,
  input  logic                   fwd_ack_i,
  input  logic [pDATA_WIDTH-1:0] fwd_dat_i,
  output logic                   tap_we_o,
  output logic                   tap_re_o,
  output logic [pADDR_WIDTH-1:0] tap_addr_o,
  output logic [pDATA_WIDTH-1:0] tap_wdata_o,
  input  logic [pDATA_WIDTH-1:0] tap_rdata_i,
  output logic [pDATA_WIDTH-1:0] data_len_o,
  input  logic                   ss_hs_i,
  input  logic                   sm_hs_i,
  output logic                   ap_start_o
);
  localparam logic [7:0] TAP_LAST = OFF_TAP + 8'(4 * (Tape_Num - 1));
  bus_state_e  bus_q;
  run_state_e  run_st;
  logic [31:0] dat_q;
  logic [31:0] data_len_q;
  logic        fwd_out_q;
  logic        clr_q;
  logic [7:0]  off;
  logic        req, run, is_tap, is_fwd, new_req, wr, rd, start;
  logic [31:0] rd_val;
  logic        unused;
  assign off = wb.wbs_adr_i[7:0];
  assign req = wb.wbs_stb_i && wb.wbs_cyc_i && wb.wbs_adr_i[31:24] == BASE_HI;
  assign run = run_st == R_RUN;
  assign is_tap = off >= OFF_TAP && off <= TAP_LAST;
  assign is_fwd = off == OFF_IN_RD || (run && (off == OFF_IN || off == OFF_OUT));
  assign new_req = bus_q == B_IDLE && req;
  assign wr = new_req && wb.wbs_we_i && !is_fwd;
  assign rd = new_req && !wb.wbs_we_i && !is_fwd;
  assign start = wr && off == OFF_CTRL && wb.wbs_dat_i[AP_START];
  assign rd_val = off == OFF_CTRL ? ap_status(run_st) : off == OFF_LEN ? data_len_q : '0;
  assign tap_we_o = wr && is_tap && !run;
  assign tap_re_o = rd && is_tap && !run;
  assign tap_addr_o = pADDR_WIDTH'(off - OFF_TAP);
  assign tap_wdata_o = wb.wbs_dat_i;
  assign data_len_o = data_len_q;
  assign fwd_stb_o = bus_q == B_FWD;
  assign fwd_out_o = fwd_out_q;
  assign wb.wbs_ack_o = bus_q == B_FWD ? fwd_ack_i : bus_q == B_ACK;
  assign wb.wbs_dat_o = bus_q == B_FWD ? (fwd_ack_i ? fwd_dat_i : '0) : (bus_q == B_ACK ? dat_q : '0);
  assign unused = ^{wb.wbs_sel_i, wb.wbs_adr_i[23:8]};
  // bus FSM: captures read data at the request so a racing run transition shows its prior state
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      bus_q      <= B_IDLE;
      dat_q      <= '0;
      data_len_q <= '0;
      fwd_out_q  <= 1'b0;
      clr_q      <= 1'b0;
    end else begin
      case (bus_q)
        B_IDLE: if (req) begin
          fwd_out_q <= off == OFF_OUT;
          clr_q     <= !wb.wbs_we_i && off == OFF_CTRL && run_st == R_DONE;
          dat_q     <= wb.wbs_we_i ? '0 : rd_val;
          if (wr && off == OFF_LEN && !run) data_len_q <= wb.wbs_dat_i;
          bus_q     <= is_fwd ? B_FWD : tap_re_o ? B_TRD : B_ACK;
        end
        B_TRD: begin
          dat_q <= tap_rdata_i;
          bus_q <= B_ACK;
        end
        B_ACK: begin
          clr_q <= 1'b0;
          bus_q <= B_IDLE;
        end
        B_FWD: if (fwd_ack_i) bus_q <= B_IDLE;
        default: bus_q <= B_IDLE;
      endcase
    end
  end
  wb_fir_ctrl_seq u_seq (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .start_i    (start),
    .clr_i      (bus_q == B_ACK && clr_q),
    .ss_hs_i    (ss_hs_i),
    .sm_hs_i    (sm_hs_i),
    .data_len_i (data_len_q),
    .state_o    (run_st),
    .ap_start_o (ap_start_o)
  );
endmodule
